// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the sequential CLA ALU:
//   - op encodings (OP_AND .. OP_MUL); codes 101 (and 011 without MUL) are illegal
//   - FSM state enum {S_IDLE, S_MUL, S_DONE}
//   - GROUP_W, the width of one carry-lookahead group
// Configuration macro: ALU_MUL_EN (see alu_seq_cla.sv). The package itself
// does not depend on it.

package alu_pkg;

    localparam int GROUP_W = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_cla_cla4_group.sv
// cla4_group
// One 4-bit carry-lookahead group. Produces the sum bits for its slice given
// the incoming group carry, plus group generate/propagate for the
// second-level lookahead in the top.
// Ports:
//   a, b   in  GROUP_W  operand slices (b already inverted for subtract)
//   cin    in  1        carry into this group
//   sum    out GROUP_W  sum slice
//   g_out  out 1        group generate
//   p_out  out 1        group propagate

module cla4_group
    import alu_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               g_out,
    output logic               p_out
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every internal carry is a flat sum-of-products of cin and the bit
    // generates/propagates, so no carry waits on a lower one.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign sum   = p ^ c;
    assign g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign p_out = &p;

endmodule

// File: rtl/alu_seq_cla.sv
// alu_seq_cla
// WIDTH-bit ALU with registered result/flags and valid/ready handshakes.
// AND/OR/NOR/ADD/SUB/SLT and illegal ops complete with latency 1; the
// optional unsigned MUL is an iterative shift-add taking WIDTH steps.
// Configuration macro: ALU_MUL_EN. When undefined the MUL state and datapath
// are removed and op 011 is reported as illegal.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, op)
//   out_valid / out_ready result handshake
//   result, result_hi    low/high WIDTH bits (result_hi only non-zero for MUL)
//   cout, ovf            carry out / signed overflow (ADD/SUB only)
//   zero                 low WIDTH bits of result are zero
//   illegal              op code was not a supported operation

module alu_seq_cla
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             illegal
);

    localparam int NG = WIDTH / GROUP_W;

    state_e state;
    logic   accept;

    // DONE accepts a new op in the same cycle its result drains, which is
    // what gives 1 result/cycle streaming; only MUL blocks new operands.
    assign in_ready = (state != S_MUL) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Subtract and compare share the adder as a + ~b + 1.
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      gc;
    logic             pp;
    logic             add_ovf;

    assign sub_mode = (op == OP_SUB) || (op == OP_SLT);
    assign b_eff    = sub_mode ? ~b : b;

    for (genvar gi = 0; gi < NG; gi++) begin : g_cla
        cla4_group u_grp (
            .a     (a[gi*GROUP_W +: GROUP_W]),
            .b     (b_eff[gi*GROUP_W +: GROUP_W]),
            .cin   (gc[gi]),
            .sum   (sum[gi*GROUP_W +: GROUP_W]),
            .g_out (grp_g[gi]),
            .p_out (grp_p[gi])
        );
    end

    // Second-level lookahead: each group carry is the OR over lower groups j
    // of G[j] propagated through P[j+1..k], plus cin propagated through all.
    always_comb begin
        pp    = 1'b1;
        gc    = '0;
        gc[0] = sub_mode;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j <= k; j++) begin
                pp = 1'b1;
                for (int m = j + 1; m <= k; m++) pp = pp & grp_p[m];
                gc[k+1] = gc[k+1] | (grp_g[j] & pp);
            end
            pp = 1'b1;
            for (int m = 0; m <= k; m++) pp = pp & grp_p[m];
            gc[k+1] = gc[k+1] | (sub_mode & pp);
        end
    end

    assign add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    logic [WIDTH-1:0] res_d;
    logic             cout_d;
    logic             ovf_d;
    logic             ill_d;

    // Single-cycle result selection; SLT uses the overflow-corrected sign.
    always_comb begin
        res_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        ill_d  = 1'b0;
        case (op)
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_NOR: res_d = ~(a | b);
            OP_ADD, OP_SUB: begin
                res_d  = sum;
                cout_d = gc[NG];
                ovf_d  = add_ovf;
            end
            OP_SLT: res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: ill_d = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // acc holds {partial high, remaining multiplier bits}; each step adds
    // the multiplicand into the high half when the current bit is set and
    // shifts the whole accumulator right by one.
    logic [WIDTH-1:0]   mul_a;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] acc_next;

    assign hi_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mul_a} : '0);
    assign acc_next = {hi_sum, acc[WIDTH-1:1]};
`endif

    // Control FSM and registered outputs. Outputs only change on accept or
    // MUL completion, so they hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
`ifdef ALU_MUL_EN
            mul_a     <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
`ifdef ALU_MUL_EN
                        if (op == OP_MUL) begin
                            mul_a     <= a;
                            acc       <= {{WIDTH{1'b0}}, b};
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            state     <= S_MUL;
                        end else begin
`else
                        begin
`endif
                            result    <= res_d;
                            result_hi <= '0;
                            cout      <= cout_d;
                            ovf       <= ovf_d;
                            zero      <= (res_d == '0);
                            illegal   <= ill_d;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result    <= acc_next[WIDTH-1:0];
                        result_hi <= acc_next[2*WIDTH-1:WIDTH];
                        cout      <= 1'b0;
                        ovf       <= 1'b0;
                        zero      <= (acc_next[WIDTH-1:0] == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
